// File: rtl/somador_multiciclo_ctrl_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding, the
// full-adder cell and a counter-width helper.
package somador_multiciclo_ctrl_pkg;

    // Encoding 2'd3 is never entered; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOMA = 2'd1,
        FIM  = 2'd2
    } state_t;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

    // Slice counter width; a single-slice adder still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/somador_fatia.sv
// SLICE-bit combinational ripple adder chained from full-adder cells; also
// exposes the carry into its MSB for signed-overflow detection.
module somador_fatia
    import somador_multiciclo_ctrl_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    always_comb begin : ripple
        logic       c;
        logic [1:0] fa;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned, which would infer a latch.
        s     = '0;
        c_msb = 1'b0;
        // NOTE: blocking assignments are correct here; c must carry each stage's result into the next iteration.
        c     = ci;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) c_msb = c;
            fa   = full_add(a[i], b[i], c);
            s[i] = fa[0];
            c    = fa[1];
        end
        co = c;
    end

endmodule

// File: rtl/somador_multiciclo_ctrl.sv
// Multi-cycle add/subtract sequencer: one SLICE-bit adder is reused over
// WIDTH/SLICE cycles with a registered carry, behind a start/done handshake.
module somador_multiciclo_ctrl
    import somador_multiciclo_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Soma,
    output logic             Cout,
    output logic             Overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("somador_multiciclo_ctrl: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [31:0]      shamt;
    logic [SLICE-1:0] f_a, f_b, f_s;
    logic             f_co, f_cmsb;
    logic             accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == LAST);
    assign ready  = (state == IDLE);
    assign busy   = (state == SOMA);
    assign done   = (state == FIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SOMA;
            SOMA:    if (last)  state_nx = FIM;
            FIM:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Select slice k of the latched operands by bit offset k*SLICE.
    assign shamt = 32'(cnt) * SLICE;
    assign f_a   = SLICE'(a_reg >> shamt);
    assign f_b   = SLICE'(b_reg >> shamt);

    somador_fatia #(.SLICE(SLICE)) u_fatia (
        .a     (f_a),
        .b     (f_b),
        .ci    (carry),
        .s     (f_s),
        .co    (f_co),
        .c_msb (f_cmsb)
    );

    // Soma is cleared on accept, so OR-ing each slice into place builds the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Soma     <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            a_reg    <= A;
            b_reg    <= B ^ {WIDTH{sub}};
            carry    <= sub ? 1'b1 : Cin;
            cnt      <= '0;
            Soma     <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (state == SOMA) begin
            Soma  <= Soma | (WIDTH'(f_s) << shamt);
            carry <= f_co;
            cnt   <= cnt + 1'b1;
            if (last) begin
                Cout     <= f_co;
                Overflow <= f_cmsb ^ f_co;
            end
        end
    end

endmodule
